// File: rtl/dma_guard.sv
// dma_guard: clocked DMA / program-counter monitor with NREG protected data
// regions and one protected code window. Raises a registered reset request
// on a violation. The request is held until the CPU re-enters the reset
// handler and then stays clean for ARM_CYCLES cycles.
//
// Ports:
//   mclk, reset_n       clock, asynchronous active-low reset
//   pc                  CPU program counter
//   dma_addr/en/we      DMA bus (any we bit set = write)
//   log_clr             clears violation log and counter (logging build)
//   reset               registered reset request (1 = hold in reset)
//   violation           registered one-cycle pulse per violating cycle
//   viol_region         registered one-hot cause, bit NREG = code window
//   log_addr/log_cause  dma_addr / cause of the first violation since clear
//   viol_cnt            saturating count of violating cycles
//
// Build option: define DMA_GUARD_LOG_EN to implement log_addr, log_cause and
// viol_cnt; otherwise they read 0 and log_clr is ignored.

`ifndef SMEM_BASE
`define SMEM_BASE 16'hE000
`endif
`ifndef SMEM_SIZE
`define SMEM_SIZE 16'h1000
`endif

// One protected data region: inclusive unsigned address match, optionally
// restricted to writes.
module dma_guard_region #(
    parameter logic [15:0] BASE = 16'h0200,
    parameter logic [15:0] LAST = 16'h02FE,
    parameter logic        WO   = 1'b0
) (
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    input  logic [1:0]  dma_we,
    output logic        hit
);
    assign hit = dma_en && (dma_addr >= BASE) && (dma_addr <= LAST) && (!WO || (|dma_we));
endmodule

module dma_guard #(
    parameter int                 NREG          = 2,
    parameter logic [16*NREG-1:0] REGION_BASE   = {16'hA000, 16'h0200},
    parameter logic [16*NREG-1:0] REGION_LAST   = {16'hA0FE, 16'h02FE},
    parameter logic [NREG-1:0]    REGION_WO     = '0,
    parameter logic [15:0]        EXEC_BASE     = `SMEM_BASE,
    parameter logic [15:0]        EXEC_LAST     = 16'(`SMEM_BASE + `SMEM_SIZE - 2),
    parameter logic [15:0]        RESET_HANDLER = 16'h0000,
    parameter int                 ARM_CYCLES    = 4,
    parameter int                 CNT_W         = 8
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic [15:0]      pc,
    input  logic [15:0]      dma_addr,
    input  logic             dma_en,
    input  logic [1:0]       dma_we,
    input  logic             log_clr,
    output logic             reset,
    output logic             violation,
    output logic [NREG:0]    viol_region,
    output logic [15:0]      log_addr,
    output logic [NREG:0]    log_cause,
    output logic [CNT_W-1:0] viol_cnt
);
    localparam logic [3:0] ARM_TGT = 4'(ARM_CYCLES);

    typedef enum logic [1:0] {KILL = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [3:0]  arm_cnt, arm_cnt_nxt;
    logic [NREG:0] hit;
    logic        viol;

    assign hit[NREG] = dma_en && (pc >= EXEC_BASE) && (pc <= EXEC_LAST);

    for (genvar g = 0; g < NREG; g++) begin : g_region
        dma_guard_region #(
            .BASE (REGION_BASE[16*g +: 16]),
            .LAST (REGION_LAST[16*g +: 16]),
            .WO   (REGION_WO[g])
        ) u_region (
            .dma_addr (dma_addr),
            .dma_en   (dma_en),
            .dma_we   (dma_we),
            .hit      (hit[g])
        );
    end

    assign viol = |hit;

    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        case (state)
            KILL: begin
                if ((pc == RESET_HANDLER) && !viol) begin
                    arm_cnt_nxt = 4'd1;
                    // A one-cycle arming period is already complete on entry.
                    state_nxt   = (ARM_TGT <= 4'd1) ? RUN : ARM;
                end
            end
            ARM: begin
                if (viol) begin
                    state_nxt = KILL;
                end else begin
                    arm_cnt_nxt = arm_cnt + 4'd1;
                    if (arm_cnt_nxt >= ARM_TGT) state_nxt = RUN;
                end
            end
            RUN:     if (viol) state_nxt = KILL;
            default: state_nxt = KILL;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= KILL;
            arm_cnt     <= 4'd0;
            reset       <= 1'b1;
            violation   <= 1'b0;
            viol_region <= '0;
        end else begin
            state       <= state_nxt;
            arm_cnt     <= arm_cnt_nxt;
            reset       <= (state_nxt != RUN);
            violation   <= viol;
            viol_region <= hit;
        end
    end

`ifdef DMA_GUARD_LOG_EN
    // A clear coinciding with a violation captures that violation as the
    // new first entry, so the log is never left empty after a hit.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            log_addr  <= '0;
            log_cause <= '0;
            viol_cnt  <= '0;
        end else if (log_clr) begin
            if (viol) begin
                log_addr  <= dma_addr;
                log_cause <= hit;
                viol_cnt  <= CNT_W'(1);
            end else begin
                log_addr  <= '0;
                log_cause <= '0;
                viol_cnt  <= '0;
            end
        end else if (viol) begin
            // log_cause is never 0 after a capture, so it marks "log empty".
            if (log_cause == '0) begin
                log_addr  <= dma_addr;
                log_cause <= hit;
            end
            if (viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_log_clr;
    assign unused_log_clr = log_clr;
    assign log_addr  = '0;
    assign log_cause = '0;
    assign viol_cnt  = '0;
`endif

endmodule

// File: tb/tb_dma_guard.sv
// Self-checking bench for dma_guard: reset state, a directed vector table
// through ARM/RUN/KILL, region/window boundaries, logging, counter
// saturation and asynchronous reset. Works in both builds.
module tb_dma_guard;
`ifdef DMA_GUARD_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        reset_n;
    logic [15:0] pc, dma_addr;
    logic        dma_en, log_clr;
    logic [1:0]  dma_we;
    logic        reset, violation;
    logic [2:0]  viol_region, log_cause;
    logic [15:0] log_addr;
    logic [7:0]  viol_cnt;
    // second instance with a one-cycle arming period
    logic        r1_reset, r1_violation;
    logic [2:0]  r1_region, r1_cause;
    logic [15:0] r1_addr;
    logic [7:0]  r1_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 mclk = ~mclk;

    dma_guard #(
        .NREG(2), .REGION_BASE({16'hA000, 16'h0200}), .REGION_LAST({16'hA0FE, 16'h02FE}),
        .REGION_WO(2'b10), .EXEC_BASE(16'hE000), .EXEC_LAST(16'hEFFE),
        .RESET_HANDLER(16'h0000), .ARM_CYCLES(4), .CNT_W(8)
    ) dut (
        .mclk(mclk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr), .dma_en(dma_en),
        .dma_we(dma_we), .log_clr(log_clr), .reset(reset), .violation(violation),
        .viol_region(viol_region), .log_addr(log_addr), .log_cause(log_cause), .viol_cnt(viol_cnt)
    );

    dma_guard #(
        .NREG(2), .REGION_BASE({16'hA000, 16'h0200}), .REGION_LAST({16'hA0FE, 16'h02FE}),
        .REGION_WO(2'b10), .EXEC_BASE(16'hE000), .EXEC_LAST(16'hEFFE),
        .RESET_HANDLER(16'h0000), .ARM_CYCLES(1), .CNT_W(8)
    ) dut1 (
        .mclk(mclk), .reset_n(reset_n), .pc(pc), .dma_addr(dma_addr), .dma_en(dma_en),
        .dma_we(dma_we), .log_clr(log_clr), .reset(r1_reset), .violation(r1_violation),
        .viol_region(r1_region), .log_addr(r1_addr), .log_cause(r1_cause), .viol_cnt(r1_cnt)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] addr;
        logic        en;
        logic [1:0]  we;
        logic        exp_rst;
        logic        exp_viol;
        logic [2:0]  exp_reg;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(logic [15:0] p, logic [15:0] a, logic e, logic [1:0] w,
                                logic r, logic v, logic [2:0] rg);
        vec_t t;
        t.pc = p; t.addr = a; t.en = e; t.we = w;
        t.exp_rst = r; t.exp_viol = v; t.exp_reg = rg;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic [15:0] a, input logic e,
                         input logic [1:0] w, input logic clr);
        pc = p; dma_addr = a; dma_en = e; dma_we = w; log_clr = clr;
    endtask

    task automatic step;
        @(posedge mclk);
        #1;
    endtask

    initial begin
        // release / ARM / RUN
        vt[0]  = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[1]  = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[2]  = mk(16'h1234, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[3]  = mk(16'h0000, 16'h0000, 0, 2'b00, 0, 0, 3'b000);
        // code-window hit
        vt[4]  = mk(16'hE000, 16'h5000, 1, 2'b00, 1, 1, 3'b100);
        vt[5]  = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[6]  = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[7]  = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[8]  = mk(16'h0000, 16'h0000, 0, 2'b00, 0, 0, 3'b000);
        // write-only region: read ignored, write hits
        vt[9]  = mk(16'h4000, 16'hA0FE, 1, 2'b00, 0, 0, 3'b000);
        vt[10] = mk(16'h4000, 16'hA0FE, 1, 2'b01, 1, 1, 3'b010);
        // violation in ARM at count 2 restarts arming
        vt[11] = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[12] = mk(16'h4000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[13] = mk(16'h4000, 16'h0200, 1, 2'b00, 1, 1, 3'b001);
        vt[14] = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[15] = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[16] = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[17] = mk(16'h0000, 16'h0000, 0, 2'b00, 0, 0, 3'b000);
        // boundaries
        vt[18] = mk(16'hF000, 16'h5000, 1, 2'b00, 0, 0, 3'b000);
        vt[19] = mk(16'h4000, 16'h01FF, 1, 2'b00, 0, 0, 3'b000);
        vt[20] = mk(16'h4000, 16'h9FFF, 1, 2'b01, 0, 0, 3'b000);
        vt[21] = mk(16'hDFFF, 16'h02FE, 1, 2'b00, 1, 1, 3'b001);
        // simultaneous window + region hit while in KILL
        vt[22] = mk(16'hEFFE, 16'h0200, 1, 2'b00, 1, 1, 3'b101);
        vt[23] = mk(16'h0000, 16'hA000, 1, 2'b00, 1, 0, 3'b000);
        vt[24] = mk(16'h0000, 16'h02FF, 1, 2'b00, 1, 0, 3'b000);
        vt[25] = mk(16'h0000, 16'h0000, 0, 2'b00, 1, 0, 3'b000);
        vt[26] = mk(16'h0000, 16'h0000, 0, 2'b00, 0, 0, 3'b000);

        reset_n = 1'b0;
        drive(16'h0000, 16'h0000, 0, 2'b00, 0);
        step;
        step;
        chk("rst_reset", reset, 1);
        chk("rst_violation", violation, 0);
        chk("rst_region", viol_region, 0);
        chk("rst_log_addr", log_addr, 0);
        chk("rst_log_cause", log_cause, 0);
        chk("rst_cnt", viol_cnt, 0);
        @(negedge mclk);
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(vt[i].pc, vt[i].addr, vt[i].en, vt[i].we, 0);
            step;
            chk($sformatf("v%0d_reset", i), reset, vt[i].exp_rst);
            chk($sformatf("v%0d_violation", i), violation, vt[i].exp_viol);
            chk($sformatf("v%0d_region", i), viol_region, vt[i].exp_reg);
            if (i == 0 || i == 5) chk($sformatf("arm1_v%0d_reset", i), r1_reset, 0);
            if (i == 4) chk("arm1_v4_reset", r1_reset, 1);
        end

        // five violations so far, first at 16'h5000 from the code window
        chk("tbl_log_addr", log_addr, LOG ? 32'h5000 : 32'h0);
        chk("tbl_log_cause", log_cause, LOG ? 32'h4 : 32'h0);
        chk("tbl_cnt", viol_cnt, LOG ? 32'd5 : 32'd0);

        // clear alone
        drive(16'h4000, 16'h0000, 0, 2'b00, 1);
        step;
        chk("clr_log_addr", log_addr, 0);
        chk("clr_cnt", viol_cnt, 0);

        // first violation captured, second only counted
        drive(16'h4000, 16'h0210, 1, 2'b00, 0);
        step;
        chk("l1_violation", violation, 1);
        chk("l1_log_addr", log_addr, LOG ? 32'h0210 : 32'h0);
        chk("l1_log_cause", log_cause, LOG ? 32'h1 : 32'h0);
        drive(16'h4000, 16'hA000, 1, 2'b01, 0);
        step;
        chk("l2_region", viol_region, 3'b010);
        chk("l2_log_addr", log_addr, LOG ? 32'h0210 : 32'h0);
        chk("l2_log_cause", log_cause, LOG ? 32'h1 : 32'h0);
        chk("l2_cnt", viol_cnt, LOG ? 32'd2 : 32'd0);

        // clear together with a violation: new violation is the log
        drive(16'h4000, 16'hA002, 1, 2'b10, 1);
        step;
        chk("l3_log_addr", log_addr, LOG ? 32'hA002 : 32'h0);
        chk("l3_log_cause", log_cause, LOG ? 32'h2 : 32'h0);
        chk("l3_cnt", viol_cnt, LOG ? 32'd1 : 32'd0);

        // saturation
        drive(16'h4000, 16'h0200, 1, 2'b00, 0);
        for (int k = 0; k < 300; k++) step;
        chk("sat_cnt", viol_cnt, LOG ? 32'd255 : 32'd0);
        chk("sat_reset", reset, 1);

        // recover, then async reset while in RUN
        drive(16'h0000, 16'h0000, 0, 2'b00, 0);
        for (int k = 0; k < 4; k++) step;
        chk("rec_reset", reset, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", reset, 1);
        chk("async_cnt", viol_cnt, 0);
        chk("async_log_cause", log_cause, 0);
        @(negedge mclk);
        reset_n = 1'b1;
        step;
        chk("post_async_reset", reset, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_guard.md
# dma_guard

Clocked, multi-region successor to the single-window DMA/PC monitor in the attestation hardware (hw-mod-auth). It watches the CPU program counter and the DMA bus every `mclk` cycle. It asserts a registered `reset` request when DMA activity coincides with execution inside the protected code window, or when DMA targets any of `NREG` protected data regions. After a violation, `reset` stays high until the CPU re-enters the reset handler and completes a clean arming period. It sits beside the other hw-mod-auth monitors, and its `reset` is ORed into the system PUC request.

## Interface

Parameters:
- `NREG`, 2 — number of protected data regions (1..4).
- `REGION_BASE`, {16'hA000,16'h0200} — packed `16*NREG`; first byte of each region (region i = bits [16i+15:16i]).
- `REGION_LAST`, {16'hA0FE,16'h02FE} — packed `16*NREG`; last word address of each region (inclusive).
- `REGION_WO`, 2'b00 — per-region bit; 1 = only DMA writes violate, 0 = any DMA access violates.
- `EXEC_BASE`, `SMEM_BASE — first address of the protected code window.
- `EXEC_LAST`, `SMEM_BASE+`SMEM_SIZE-2 — last address of the protected code window (inclusive).
- `RESET_HANDLER`, 16'h0000 — PC value that starts recovery.
- `ARM_CYCLES`, 4 — consecutive clean cycles at or after the handler before leaving ARM (1..15).
- `CNT_W`, 8 — violation counter width.

Ports:
- `mclk` in 1 — system clock; all state changes on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `pc` in 16 — current CPU program counter.
- `dma_addr` in 16 — DMA address.
- `dma_en` in 1 — DMA access this cycle.
- `dma_we` in 2 — DMA byte write enables; any bit set = write.
- `log_clr` in 1 — clears log and counter (logging build only).
- `reset` out 1 — registered reset request; 1 = hold system in reset.
- `violation` out 1 — registered one-cycle pulse per violating cycle.
- `viol_region` out `NREG+1` — registered one-hot cause; bit `NREG` = code window, bit i = data region i.
- `log_addr` out 16 — `dma_addr` of the first violation since clear.
- `log_cause` out `NREG+1` — `viol_region` value of the first violation since clear.
- `viol_cnt` out `CNT_W` — saturating count of violating cycles.

## Operation

Comparisons are unsigned and inclusive at both ends.

Violation conditions, evaluated combinationally each cycle:
- `hit_exec` = `dma_en` AND `EXEC_BASE` <= pc <= `EXEC_LAST`.
- `hit_i` = `dma_en` AND `REGION_BASE[i]` <= `dma_addr` <= `REGION_LAST[i]` AND (`REGION_WO[i]`==0 OR |`dma_we`).
- `viol` = OR of all hits. Multiple simultaneous hits set multiple bits in `viol_region`.

State machine (2-bit):
- **KILL**: `reset`=1.
  - `pc`==`RESET_HANDLER` and !`viol` → ARM, with the arm counter loaded to 1.
- **ARM**: `reset`=1.
  - `viol` → KILL.
  - Otherwise increment the arm counter; on reaching `ARM_CYCLES` → RUN.
  - `pc` need not stay at the handler while in ARM.
- **RUN**: `reset`=0.
  - `viol` → KILL.

Registered outputs:
- `reset` = 1 when next state ≠ RUN.
- `violation` = `viol`.
- `viol_region` = the hit vector.

A violation in KILL still pulses `violation` and is logged; it does not alter the state.

## Timing

- Reset values, while `reset_n`=0: state KILL, `reset`=1, `violation`=0, `viol_region`=0, `log_addr`=0, `log_cause`=0, `viol_cnt`=0, arm counter=0.
- Violation at edge t (sampled) → `reset`=1 and `violation`=1 after edge t. Latency is 1 cycle.
- Clean handler entry at edge t → `reset` falls after edge t+`ARM_CYCLES`-1. With `ARM_CYCLES`=1, it falls after edge t.
- Asserting `reset_n` mid-ARM or mid-RUN returns to KILL immediately, with no clock required.
- `viol_cnt` saturates at all-ones with no wrap.
- `log_clr` together with a violation in the same cycle: the clear wins, then the new violation is captured, so the log holds the new violation and `viol_cnt`=1.

## Configuration

- `DMA_GUARD_LOG_EN` defined:
  - `log_addr`, `log_cause` and `viol_cnt` are implemented.
  - The log captures only when `log_cause`==0, i.e. the first violation since reset or clear.
- `DMA_GUARD_LOG_EN` undefined:
  - `log_addr`, `log_cause` and `viol_cnt` are tied to 0 and `log_clr` is ignored.
  - All other behaviour is identical.

## Test plan

- Release `reset_n`, `pc`=16'h0000, no DMA for 4 cycles → `reset` stays 1 for cycles 1-3 and is 0 from cycle 4 (ARM_CYCLES=4).
- RUN, `pc`=`EXEC_BASE`, `dma_en`=1 for one cycle → next cycle `reset`=1, `violation`=1 for one cycle, `viol_region`=3'b100.
- RUN, `dma_addr`=16'hA0FE with `dma_we`=0 and `REGION_WO`=2'b10 → no violation. Same cycle with `dma_we`=2'b01 → `viol_region`=3'b010, `reset`=1.
- ARM at count 2, `dma_addr`=16'h0200 read → back to KILL, `reset` held 1. A later clean handler entry requires the full 4 cycles again.
- `DMA_GUARD_LOG_EN`: violation at 16'h0210 then 16'hA000 → `log_addr`=16'h0210, `log_cause`=3'b001, `viol_cnt`=2. Then `log_clr` together with a violation at 16'hA002 → `log_addr`=16'hA002, `viol_cnt`=1.
- Boundaries: `pc`=`EXEC_LAST`+2 with DMA → no hit. `dma_addr`=`REGION_BASE`-1 → no hit. Force 300 violations with `CNT_W`=8 → `viol_cnt`=255.
